// File: rtl/seq_ser_pkg.sv
// Shared types and helpers for the bit serializer feeding the 1011 sequence detector.
package seq_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_e;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// PISO serializer: valid/ready word in, one bit per clock out on x, zero-gap streaming.
// Optional macro SER_PARITY_EN appends an even-parity bit (state PAR) after each word.
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             x_nxt;
  logic             rdy_en;
  logic             last_bit;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par_bit, par_nxt;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last_bit = (state == SHIFT) && (cnt == LAST);

  // rdy_en keeps in_ready low until one full clock after reset releases.
`ifdef SER_PARITY_EN
  assign done     = (state == PAR);
  assign in_ready = reset && rdy_en && ((state == IDLE) || (state == PAR));
`else
  assign done     = last_bit;
  assign in_ready = reset && rdy_en && ((state == IDLE) || last_bit);
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
`ifdef SER_PARITY_EN
    par_nxt   = par_bit;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = in_data;
          cnt_nxt   = '0;
`ifdef SER_PARITY_EN
          par_nxt   = ^in_data;
`endif
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef SER_PARITY_EN
          state_nxt = PAR;
          cnt_nxt   = '0;
`else
          if (accept) begin
            sreg_nxt = in_data;
            cnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            cnt_nxt   = '0;
          end
`endif
        end else begin
          sreg_nxt = shift_word(sreg);
          cnt_nxt  = cnt + CW'(1);
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = in_data;
          cnt_nxt   = '0;
          par_nxt   = ^in_data;
        end else begin
          state_nxt = IDLE;
          sreg_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        sreg_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase

    // x is registered: compute the bit that will be on the line after this edge.
    x_nxt = IDLE_LEVEL;
    if (state_nxt == SHIFT) begin
      x_nxt = head_bit(sreg_nxt);
    end
`ifdef SER_PARITY_EN
    else if (state_nxt == PAR) begin
      x_nxt = par_nxt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      x       <= IDLE_LEVEL;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      rdy_en  <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      cnt     <= cnt_nxt;
      x       <= x_nxt;
      x_valid <= (state_nxt != IDLE);
      busy    <= (state_nxt != IDLE);
      rdy_en  <= 1'b1;
`ifdef SER_PARITY_EN
      par_bit <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: a 4-bit MSB-first and an 8-bit LSB-first instance against a bit-stream model.
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int W0 = 4;
  localparam int W1 = 8;
  localparam int P0 = W0 + PB;
  localparam int P1 = W1 + PB;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d0;
  logic [7:0] d1;
  logic [1:0] iv;
  logic [1:0] rdy, xs, xv, bz, dn;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W0), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(iv[0]), .in_ready(rdy[0]),
    .x(xs[0]), .x_valid(xv[0]), .busy(bz[0]), .done(dn[0])
  );

  seq_bit_serializer #(.WIDTH(W1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(iv[1]), .in_ready(rdy[1]),
    .x(xs[1]), .x_valid(xv[1]), .busy(bz[1]), .done(dn[1])
  );

  int total = 0;
  int bad   = 0;

  // Model: pend holds the bits still to appear on x, bit 0 = bit on the line now.
  logic [63:0] pend[2];
  int          pcnt[2];
  bit          rs[2];
  bit          acc[2];
  int          acc_cyc[2];
  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_xfer;

  function automatic logic [63:0] stream_bits(input int d, input logic [7:0] w);
    logic [63:0] r;
    int wd;
    r  = '0;
    wd = (d == 1) ? W1 : W0;
    for (int i = 0; i < wd; i++) r[i] = (d == 0) ? w[wd-1-i] : w[i];
    if (PB == 1) r[wd] = ^w;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    chk_en = 1;
    for (int d = 0; d < 2; d++) begin
      acc[d] = 0;
      if (!reset) begin
        pend[d] = '0;
        pcnt[d] = 0;
        rs[d]   = 0;
      end else begin
        m_xfer = iv[d] && rs[d] && (pcnt[d] <= 1);
        if (pcnt[d] > 0) begin
          pend[d] = pend[d] >> 1;
          pcnt[d]--;
        end
        if (m_xfer) begin
          pend[d]    = pend[d] | (stream_bits(d, (d == 1) ? d1 : {4'b0, d0}) << pcnt[d]);
          pcnt[d]    = pcnt[d] + ((d == 1) ? P1 : P0);
          acc[d]     = 1;
          acc_cyc[d] = cyc;
        end
        rs[d] = 1;
      end
    end
  end

  bit    cap0[$];
  bit    cap1[$];
  int    done_cnt[2] = '{0, 0};
  int    req_seq = 0;
  int    ack_seq = 0;
  string lit_nm;
  logic [31:0] lit_act, lit_exp;

  // Single compare process: per-cycle model check plus queued literal checks.
  always @(negedge clk) begin
    logic [4:0] e, a;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        e = {reset && rs[d] && (pcnt[d] <= 1), pcnt[d] > 0, pcnt[d] == 1,
             pcnt[d] > 0, (pcnt[d] > 0) ? pend[d][0] : 1'b0};
        a = {rdy[d], bz[d], dn[d], xv[d], xs[d]};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle%0d dut%0d {rdy,busy,done,xv,x} got=%b want=%b", cyc, d, a, e);
        end
        if (xv[d] === 1'b1) begin
          if (d == 0) cap0.push_back(xs[d]);
          else        cap1.push_back(xs[d]);
        end
        if (dn[d] === 1'b1) done_cnt[d]++;
      end
    end
    if (req_seq != ack_seq) begin
      ack_seq = req_seq;
      total++;
      if (lit_act !== lit_exp) begin
        bad++;
        $display("FAIL %s got=%0h want=%0h", lit_nm, lit_act, lit_exp);
      end
    end
  end

  task automatic check_lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_nm  = nm;
    lit_act = act;
    lit_exp = exp;
    req_seq++;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input logic [7:0] w);
    bit got;
    got = 0;
    if (d == 0) d0 = w[3:0];
    else        d1 = w;
    iv[d] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc[d]) got = 1;
    end
    if (!got) check_lit("accept_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] capv(input int d, input int mark, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (d == 0) v = (mark + i < cap0.size()) ? {v[30:0], cap0[mark+i]} : {v[30:0], 1'bx};
      else        v = (mark + i < cap1.size()) ? {v[30:0], cap1[mark+i]} : {v[30:0], 1'bx};
    end
    return v;
  endfunction

  initial begin
    int mark, dmark, c1;
    reset = 1'b0;
    iv    = 2'b11;
    d0    = 4'b1011;
    d1    = 8'h00;

    // Reset hold with in_valid high
    tick(3);
    check_lit("reset_in_ready", {30'd0, rdy}, 32'd0);
    check_lit("reset_xv_x", {28'd0, xv, xs}, 32'd0);
    iv    = 2'b00;
    reset = 1'b1;
    tick(1);
    check_lit("ready_after_release", {30'd0, rdy}, 32'd3);

    // Single word 1011, MSB first
    mark  = cap0.size();
    dmark = done_cnt[0];
    send(0, 8'h0B);
    iv[0] = 1'b0;
    tick(P0 + 2);
    if (PB == 1) check_lit("single_1011_par", capv(0, mark, P0), 32'b10111);
    else         check_lit("single_1011", capv(0, mark, P0), 32'b1011);
    check_lit("single_done_count", done_cnt[0] - dmark, 32'd1);

    // Streaming 1101 then 1000 without a gap
    mark  = cap0.size();
    dmark = done_cnt[0];
    send(0, 8'h0D);
    c1 = acc_cyc[0];
    send(0, 8'h08);
    iv[0] = 1'b0;
    check_lit("stream_accept_gap", acc_cyc[0] - c1, P0);
    tick(P0 + 2);
    if (PB == 1) check_lit("stream_bits_par", capv(0, mark, 2 * P0), 32'b1101110001);
    else         check_lit("stream_bits", capv(0, mark, 2 * P0), 32'b11011000);
    check_lit("stream_done_count", done_cnt[0] - dmark, 32'd2);

    // LSB first, 8'hB4
    mark = cap1.size();
    send(1, 8'hB4);
    iv[1] = 1'b0;
    tick(P1 + 2);
    if (PB == 1) check_lit("lsb_b4_par", capv(1, mark, P1), 32'b001011010);
    else         check_lit("lsb_b4", capv(1, mark, P1), 32'b00101101);

    // Reset mid-word, then a fresh word 1001
    mark = cap0.size();
    send(0, 8'h0B);
    iv[0] = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    check_lit("midreset_xv_busy_x", {29'd0, xv[0], bz[0], xs[0]}, 32'd0);
    reset = 1'b1;
    tick(1);
    send(0, 8'h09);
    iv[0] = 1'b0;
    tick(P0 + 2);
    if (PB == 1) check_lit("midreset_fresh_par", capv(0, mark, 2 + P0), 32'b1010010);
    else         check_lit("midreset_fresh", capv(0, mark, 2 + P0), 32'b101001);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
